cordic_iter_engine: RTL

Parametrised iterative CORDIC engine. It computes one rotation-mode or vectoring-mode CORDIC operation per transaction, one micro-rotation per clock. Inputs and outputs use valid/ready handshakes, and the arctangent table is built in. It sits between the sample datapath and the phase/magnitude consumers and replaces the stand-alone arctangent table as the unit that performs the trig work.

---
 rtl/cordic_iter_engine.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine: one rotation- or vectoring-mode operation per transaction,
// one micro-rotation per clock, valid/ready handshakes on input and output.
module cordic_iter_engine #(
    parameter int DATA_W  = 16,
    parameter int ANGLE_W = 32,
    parameter int ITER    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_mode,
    input  logic signed [DATA_W-1:0]  in_x,
    input  logic signed [DATA_W-1:0]  in_y,
    input  logic signed [ANGLE_W-1:0] in_z,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [DATA_W+1:0]  out_x,
    output logic signed [DATA_W+1:0]  out_y,
    output logic signed [ANGLE_W-1:0] out_z
);

    localparam int XW    = DATA_W + 2;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);
    localparam logic signed [31:0] HALF_PI_32 = 32'sh3243F6A9;
    localparam logic signed [ANGLE_W-1:0] HALF_PI = ANGLE_W'(HALF_PI_32 >>> (32 - ANGLE_W));

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_ITER, S_DONE} state_t;

    // atan(2^-i) in Q3.29 radians, narrowed to ANGLE_W by arithmetic shift.
    function automatic logic signed [ANGLE_W-1:0] atan_lut(input logic [4:0] idx);
        logic signed [31:0] v;
        case (idx)
            5'd0:    v = 32'sd421657428;
            5'd1:    v = 32'sd248918915;
            5'd2:    v = 32'sd131521918;
            5'd3:    v = 32'sd66762579;
            5'd4:    v = 32'sd33510843;
            5'd5:    v = 32'sd16771758;
            5'd6:    v = 32'sd8387925;
            5'd7:    v = 32'sd4194219;
            5'd8:    v = 32'sd2097141;
            5'd9:    v = 32'sd1048575;
            5'd10:   v = 32'sd524288;
            5'd11:   v = 32'sd262144;
            5'd12:   v = 32'sd131072;
            5'd13:   v = 32'sd65536;
            5'd14:   v = 32'sd32768;
            5'd15:   v = 32'sd16384;
            5'd16:   v = 32'sd8192;
            5'd17:   v = 32'sd4096;
            5'd18:   v = 32'sd2048;
            5'd19:   v = 32'sd1024;
            5'd20:   v = 32'sd512;
            5'd21:   v = 32'sd256;
            5'd22:   v = 32'sd128;
            5'd23:   v = 32'sd64;
            5'd24:   v = 32'sd32;
            5'd25:   v = 32'sd16;
            5'd26:   v = 32'sd8;
            5'd27:   v = 32'sd4;
            5'd28:   v = 32'sd2;
            5'd29:   v = 32'sd1;
            default: v = 32'sd0;
        endcase
        return ANGLE_W'(v >>> (32 - ANGLE_W));
    endfunction

    state_t                    r_state, w_state_nxt;
    logic signed [XW-1:0]      r_x, r_y, w_x_nxt, w_y_nxt, w_x_sh, w_y_sh;
    logic signed [ANGLE_W-1:0] r_z, w_z_nxt, w_atan;
    logic                      r_mode, w_mode_nxt;
    logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
    logic                      w_dir_pos;

    assign w_x_sh    = r_x >>> r_cnt;
    assign w_y_sh    = r_y >>> r_cnt;
    assign w_atan    = atan_lut(5'(r_cnt));
    assign w_dir_pos = r_mode ? r_y[XW-1] : ~r_z[ANGLE_W-1];

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_x     = r_x;
    assign out_y     = r_y;
    assign out_z     = r_z;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_z_nxt     = r_z;
        w_mode_nxt  = r_mode;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_x_nxt     = {{2{in_x[DATA_W-1]}}, in_x};
                    w_y_nxt     = {{2{in_y[DATA_W-1]}}, in_y};
                    w_z_nxt     = in_z;
                    w_mode_nxt  = in_mode;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_PRE;
                end
            end
            S_PRE: begin
                // Fold the operand into the right half-plane so the iterations can converge.
                if (!r_mode) begin
                    if (r_z > HALF_PI) begin
                        w_x_nxt = -r_y;  w_y_nxt = r_x;  w_z_nxt = r_z - HALF_PI;
                    end else if (r_z < -HALF_PI) begin
                        w_x_nxt = r_y;   w_y_nxt = -r_x; w_z_nxt = r_z + HALF_PI;
                    end
                end else if (r_x[XW-1]) begin
                    if (!r_y[XW-1]) begin
                        w_x_nxt = r_y;   w_y_nxt = -r_x; w_z_nxt = r_z + HALF_PI;
                    end else begin
                        w_x_nxt = -r_y;  w_y_nxt = r_x;  w_z_nxt = r_z - HALF_PI;
                    end
                end
                w_cnt_nxt   = '0;
                w_state_nxt = S_ITER;
            end
            S_ITER: begin
                if (w_dir_pos) begin
                    w_x_nxt = r_x - w_y_sh;
                    w_y_nxt = r_y + w_x_sh;
                    w_z_nxt = r_z - w_atan;
                end else begin
                    w_x_nxt = r_x + w_y_sh;
                    w_y_nxt = r_y - w_x_sh;
                    w_z_nxt = r_z + w_atan;
                end
                if (r_cnt == LAST_CNT) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from old values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_mode <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_x    <= w_x_nxt;
            r_y    <= w_y_nxt;
            r_z    <= w_z_nxt;
            r_mode <= w_mode_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

endmodule
